// File: rtl/reg_writeback_pkg.sv
// Shared definitions for the register writeback buffer: control bit positions,
// register/data widths, the link register number and the buffered entry layout.
package reg_writeback_pkg;

  localparam int REG_W  = 5;
  localparam int DATA_W = 32;
  localparam int CNT_W  = 4;   // holds 0..8 entries
  localparam int DROP_W = 16;

  localparam logic [REG_W-1:0] LINK_REG = 5'd31;

  // in_ctrl = {RegWrite, RegDst, MemToReg, Link}
  localparam int CTRL_REGWRITE = 3;
  localparam int CTRL_REGDST   = 2;
  localparam int CTRL_MEMTOREG = 1;
  localparam int CTRL_LINK     = 0;

  typedef struct packed {
    logic [REG_W-1:0]  addr;
    logic [DATA_W-1:0] data;
  } wb_entry_t;

  // Destination register: Link forces $31, otherwise RegDst picks rd over rt.
  function automatic logic [REG_W-1:0] wb_dest(input logic [REG_W-1:0] rt,
                                               input logic [REG_W-1:0] rd,
                                               input logic [3:0]       ctrl);
    if (ctrl[CTRL_LINK])        return LINK_REG;
    else if (ctrl[CTRL_REGDST]) return rd;
    else                        return rt;
  endfunction

endpackage

// File: rtl/reg_writeback_wb_fifo.sv
// Pending-write FIFO. Exposes its contents in age order (index 0 = head,
// oldest) together with a per-slot valid mask so the top can both retire the
// head and search every pending write for bypass.
module wb_fifo
  import reg_writeback_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  wb_entry_t              push_entry,
  input  logic                   pop,
  output logic [CNT_W-1:0]       count,
  output wb_entry_t [DEPTH-1:0]  ordered,
  output logic [DEPTH-1:0]       ordered_valid
);

  localparam int PTR_W = $clog2(DEPTH);

  wb_entry_t [DEPTH-1:0] mem_q, mem_d;
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  push_ok, pop_ok;
  logic [PTR_W:0]        idx;

  // Never push into a full buffer or pop an empty one, whatever the caller does.
  assign push_ok = push && (count_q < CNT_W'(DEPTH));
  assign pop_ok  = pop && (count_q != '0);

  // Next-state: storage write, pointer wrap modulo DEPTH, occupancy update
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = push_entry;
      wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
    end
    if (pop_ok) begin
      rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
    end
    if (push_ok && !pop_ok)      count_d = count_q + 1'b1;
    else if (!push_ok && pop_ok) count_d = count_q - 1'b1;
  end

  // State registers; reset empties the buffer and clears storage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Age-ordered view: slot i is the i-th oldest pending entry
  always_comb begin
    idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = {1'b0, rd_ptr_q} + (PTR_W + 1)'(i);
      if (idx >= (PTR_W + 1)'(DEPTH)) idx = idx - (PTR_W + 1)'(DEPTH);
      ordered[i]       = mem_q[idx[PTR_W-1:0]];
      ordered_valid[i] = (CNT_W'(i) < count_q);
    end
  end

  assign count = count_q;

endmodule

// File: rtl/reg_writeback.sv
// Writeback stage with a small pending-write buffer between MEM and the
// register file. Results are steered to a destination, writes that would be
// no-ops are counted and dropped, and the rest retire in order as the register
// file allows. Optional decode bypass is enabled with the WB_BYPASS_EN macro.
//
// Handshake: a result transfers on any rising edge where in_valid && in_ready;
// in_ready depends only on buffer occupancy. On the register-file side rf_we
// is the head-valid flop gated by rf_stall, and the head retires on every edge
// where rf_we is high; rf_waddr/rf_wdata come straight from head storage.
module reg_writeback
  import reg_writeback_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_instr,
  input  logic [DATA_W-1:0] in_alu,
  input  logic [DATA_W-1:0] in_mem,
  input  logic [3:0]        in_ctrl,
  input  logic              rf_stall,
  output logic              rf_we,
  output logic [REG_W-1:0]  rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  input  logic [REG_W-1:0]  q_rs,
  input  logic [REG_W-1:0]  q_rt,
  output logic              q_rs_hit,
  output logic              q_rt_hit,
  output logic [DATA_W-1:0] q_rs_data,
  output logic [DATA_W-1:0] q_rt_data,
  output logic [DROP_W-1:0] drop_cnt
);

  logic [REG_W-1:0]      dest;
  logic [DATA_W-1:0]     wdata;
  logic                  transfer, keep, push, pop;
  wb_entry_t             push_entry;
  logic [CNT_W-1:0]      count;
  wb_entry_t [DEPTH-1:0] ord;
  logic [DEPTH-1:0]      ord_valid;
  logic [DROP_W-1:0]     drop_cnt_q, drop_cnt_d;
  logic                  unused_instr;

  // Only rt and rd are meaningful in the instruction word here.
  assign unused_instr = ^{in_instr[31:21], in_instr[10:0]};

  // Steer destination and write data from the control bits
  always_comb begin
    dest = wb_dest(in_instr[20:16], in_instr[15:11], in_ctrl);
    if (in_ctrl[CTRL_LINK])          wdata = in_alu;
    else if (in_ctrl[CTRL_MEMTOREG]) wdata = in_mem;
    else                             wdata = in_alu;
  end

  assign in_ready   = (count < CNT_W'(DEPTH));
  assign transfer   = in_valid && in_ready;
  assign keep       = in_ctrl[CTRL_REGWRITE] && (dest != '0);
  assign push       = transfer && keep;
  assign push_entry = '{addr: dest, data: wdata};

  assign rf_we    = ord_valid[0] && !rf_stall;
  assign pop      = rf_we;
  assign rf_waddr = ord[0].addr;
  assign rf_wdata = ord[0].data;

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk           (clk),
    .rst_n         (rst_n),
    .push          (push),
    .push_entry    (push_entry),
    .pop           (pop),
    .count         (count),
    .ordered       (ord),
    .ordered_valid (ord_valid)
  );

  // Saturating count of accepted results that produce no register write
  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (transfer && !keep && (drop_cnt_q != '1)) drop_cnt_d = drop_cnt_q + 1'b1;
  end

  // Drop counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) drop_cnt_q <= '0;
    else        drop_cnt_q <= drop_cnt_d;
  end

  assign drop_cnt = drop_cnt_q;

`ifdef WB_BYPASS_EN
  // Search pending writes oldest to newest so the newest match wins
  always_comb begin
    q_rs_hit  = 1'b0;
    q_rs_data = '0;
    q_rt_hit  = 1'b0;
    q_rt_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ord_valid[i] && (q_rs != '0) && (ord[i].addr == q_rs)) begin
        q_rs_hit  = 1'b1;
        q_rs_data = ord[i].data;
      end
      if (ord_valid[i] && (q_rt != '0) && (ord[i].addr == q_rt)) begin
        q_rt_hit  = 1'b1;
        q_rt_data = ord[i].data;
      end
    end
  end
`else
  logic unused_bypass;
  assign unused_bypass = ^{q_rs, q_rt, ord, ord_valid};
  assign q_rs_hit  = 1'b0;
  assign q_rt_hit  = 1'b0;
  assign q_rs_data = '0;
  assign q_rt_data = '0;
`endif

endmodule
